// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FROZEN = 2'd3
  } state_t;

  localparam int unsigned FLUSH_CYCLES_DEF = 1;
  localparam int unsigned MAX_STALL_DEF    = 3;
  localparam int unsigned STALL_CNT_W      = 3;
  localparam int unsigned FLUSH_CNT_W      = 2;

  typedef struct packed {
    logic pc_write;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_ctrl_flush;
    logic id_ex_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, if_id_hold: 1'b0, if_id_flush: 1'b0,
                                   id_ex_ctrl_flush: 1'b0, id_ex_hold: 1'b0};
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_id_hold: 1'b1, if_id_flush: 1'b0,
                                   id_ex_ctrl_flush: 1'b1, id_ex_hold: 1'b0};
  localparam ctrl_t CTRL_BR    = '{pc_write: 1'b1, if_id_hold: 1'b0, if_id_flush: 1'b1,
                                   id_ex_ctrl_flush: 1'b1, id_ex_hold: 1'b0};
  localparam ctrl_t CTRL_FL    = '{pc_write: 1'b1, if_id_hold: 1'b0, if_id_flush: 1'b1,
                                   id_ex_ctrl_flush: 1'b0, id_ex_hold: 1'b0};
  localparam ctrl_t CTRL_FRZ   = '{pc_write: 1'b0, if_id_hold: 1'b1, if_id_flush: 1'b0,
                                   id_ex_ctrl_flush: 1'b0, id_ex_hold: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear (priority) and enable.
module sat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard-stall / branch-flush / freeze controller with Mealy control outputs.
// Define STALL_STATS_EN to add the stall_cycles / flush_events statistics outputs.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned MAX_STALL    = MAX_STALL_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hasHazard,
  input  logic        branch_taken,
  input  logic        freeze,
  output logic        PCWrite,
  output logic        IF_ID_Hold,
  output logic        IF_ID_Flush,
  output logic        ID_EX_CtrlFlush,
  output logic        ID_EX_Hold,
  output logic        stall_timeout,
  output logic [1:0]  state
`ifdef STALL_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST  = FLUSH_CNT_W'(FLUSH_CYCLES - 2);
  localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(MAX_STALL);

  state_t                  state_q, state_d, saved_q, saved_d, eff_state;
  logic                    timeout_q, timeout_d;
  logic                    stall_clr, stall_en, flush_clr, flush_en;
  logic [STALL_CNT_W-1:0]  stall_cnt;
  logic [FLUSH_CNT_W-1:0]  flush_cnt;
  ctrl_t                   ctrl;

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk     (clock),
    .rst_n   (reset),
    .clr_i   (stall_clr),
    .en_i    (stall_en),
    .count_o (stall_cnt)
  );

  // Counts FLUSH-state cycles already spent since the last taken branch.
  sat_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
    .clk     (clock),
    .rst_n   (reset),
    .clr_i   (flush_clr),
    .en_i    (flush_en),
    .count_o (flush_cnt)
  );

  // On the first unfrozen cycle the saved state takes over as if never frozen.
  assign eff_state = (state_q == FROZEN) ? saved_q : state_q;

  always_comb begin
    ctrl      = CTRL_RUN;
    state_d   = state_q;
    saved_d   = saved_q;
    timeout_d = timeout_q;
    stall_clr = 1'b0;
    stall_en  = 1'b0;
    flush_clr = 1'b0;
    flush_en  = 1'b0;
    if (freeze) begin
      ctrl    = CTRL_FRZ;
      state_d = FROZEN;
      if (state_q != FROZEN) begin
        saved_d = state_q;
      end
    end else if (branch_taken) begin
      ctrl      = CTRL_BR;
      stall_clr = 1'b1;
      flush_clr = 1'b1;
      state_d   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (eff_state == FLUSH) begin
      ctrl      = CTRL_FL;
      stall_clr = 1'b1;
      if (flush_cnt == FLUSH_LAST) begin
        flush_clr = 1'b1;
        state_d   = RUN;
      end else begin
        flush_en = 1'b1;
        state_d  = FLUSH;
      end
    end else if (hasHazard) begin
      ctrl     = CTRL_STALL;
      stall_en = 1'b1;
      state_d  = STALL;
      if (stall_cnt >= STALL_LIMIT) begin
        timeout_d = 1'b1;
      end
    end else begin
      stall_clr = 1'b1;
      state_d   = RUN;
    end
    if (!reset) begin
      ctrl = CTRL_RUN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      saved_q   <= RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      timeout_q <= timeout_d;
    end
  end

  assign PCWrite         = ctrl.pc_write;
  assign IF_ID_Hold      = ctrl.if_id_hold;
  assign IF_ID_Flush     = ctrl.if_id_flush;
  assign ID_EX_CtrlFlush = ctrl.id_ex_ctrl_flush;
  assign ID_EX_Hold      = ctrl.id_ex_hold;
  assign stall_timeout   = timeout_q;
  assign state           = 2'(state_q);

`ifdef STALL_STATS_EN
  logic [15:0] stall_cycles_q, flush_events_q;

  // A control-flush without IF/ID flush is a hazard stall; with it, a taken branch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 16'd0;
      flush_events_q <= 16'd0;
    end else if (ctrl.id_ex_ctrl_flush) begin
      if (ctrl.if_id_flush) begin
        flush_events_q <= flush_events_q + 16'd1;
      end else begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule
